serial_ripple_adder: RTL

Parametrised, multi-cycle ripple-carry adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock. A registered carry links successive digits. A valid/ready handshake sits on both the input and output sides. It is the sequential successor to the team's 8-bit combinational ripple-carry adder, and trades latency for a small DIGIT-bit carry chain in arithmetic datapaths.

---
 rtl/rca_pkg.sv | 18 +
 rtl/digit_adder.sv | 31 +++
 rtl/serial_ripple_adder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared types and constants for the serial ripple-carry adder/subtractor.
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIGIT = 2;

    // Number of digit cycles needed to sweep a full operand.
    function automatic int rca_num_digits(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder slice; also exposes the carry into its MSB
// so the caller can derive signed overflow on the most significant digit.
module digit_adder
    import rca_pkg::*;
#(
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin
        logic carry;
        s     = '0;
        c_msb = cin;
        carry = cin;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/serial_ripple_adder.sv
// Multi-cycle ripple-carry adder processing DIGIT bits per clock with valid/ready on
// both sides. Define RCA_SUB_EN to add the Sub port and A - B - Cin mode.
module serial_ripple_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef RCA_SUB_EN
    input  logic             Sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int N  = rca_num_digits(WIDTH, DIGIT);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int NP = 1 << KW;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    generate
        if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_ripple_adder: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovf_q;
    logic             capture, load_out, run_en;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Subtraction is folded into the captured operand: A + ~B + ~Cin.
`ifdef RCA_SUB_EN
    assign b_eff   = Sub ? ~B : B;
    assign cin_eff = Sub ? ~Cin : Cin;
`else
    assign b_eff   = B;
    assign cin_eff = Cin;
`endif

    logic [DIGIT-1:0] a_dig [NP];
    logic [DIGIT-1:0] b_dig [NP];
    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic             dig_cout, dig_cmsb;

    // Digit table padded to a power of two so the counter indexes it directly.
    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_dig
            if (gi < N) begin : g_real
                assign a_dig[gi] = a_q[gi*DIGIT +: DIGIT];
                assign b_dig[gi] = b_q[gi*DIGIT +: DIGIT];
            end else begin : g_pad
                assign a_dig[gi] = '0;
                assign b_dig[gi] = '0;
            end
        end
    endgenerate

    assign dig_a = a_dig[k_q];
    assign dig_b = b_dig[k_q];

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (dig_a),
        .b     (dig_b),
        .cin   (carry_q),
        .s     (dig_s),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    assign run_en = (state_q == RUN);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sum
            assign sum_d[gi*DIGIT +: DIGIT] = (run_en && k_q == KW'(gi)) ? dig_s
                                                                        : sum_q[gi*DIGIT +: DIGIT];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        carry_d  = carry_q;
        capture  = 1'b0;
        load_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    k_d     = '0;
                    carry_d = cin_eff;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = dig_cout;
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    load_out = 1'b1;
                    k_d      = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            if (capture) begin
                a_q <= A;
                b_q <= b_eff;
            end
            // Published results only change when a new result completes.
            if (load_out) begin
                s_q    <= sum_d;
                cout_q <= dig_cout;
                ovf_q  <= dig_cmsb ^ dig_cout;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule
